// File: rtl/down_timer_pkg.sv
// Shared definitions for the timer/counter family: FSM state encoding and
// the period clamp used when a new period is written.
package down_timer_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Limit a requested period to the largest value the counter may hold.
    function automatic int unsigned clamp_period(input int unsigned val,
                                                 input int unsigned max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/down_timer.sv
// Loadable down-counting timer. Counts a programmable period down to zero on
// clock-enable ticks, pulses tc for one cycle at each terminal tick and can
// optionally reload itself to act as a periodic tick generator.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned WIDTH = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ce,
    input  logic             i_load,
    input  logic [WIDTH:0]   i_load_val,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_auto_reload,
    output logic [WIDTH:0]   o_y,
    output logic             o_tc,
    output logic             o_busy
);

    localparam int unsigned W = WIDTH + 1;

    state_e         r_state;
    logic [WIDTH:0] r_y;
    logic [WIDTH:0] r_period;
    logic           r_tc;

    logic [WIDTH:0] w_load_clamped;
    logic [WIDTH:0] w_eff_period;
    logic [WIDTH:0] w_reload_val;
    logic           w_reload_ok;

    assign w_load_clamped = W'(clamp_period(32'(i_load_val), N));

    // A load in the same cycle as start takes effect immediately.
    assign w_eff_period = i_load ? w_load_clamped : r_period;

    // Auto-reload uses the stored period; a zero period cannot keep running.
    assign w_reload_val = r_period;
    assign w_reload_ok  = i_auto_reload && (r_period != '0);

    // FSM, period register, counter and terminal-count pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_y      <= '0;
            r_period <= W'(N);
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (i_load) begin
                r_period <= w_load_clamped;
            end
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        if (w_eff_period != '0) begin
                            r_y     <= w_eff_period;
                            r_state <= StRun;
                        end else begin
                            r_tc <= 1'b1;
                            r_y  <= '0;
                        end
                    end
                end
                StRun: begin
                    if (i_stop) begin
                        r_state <= StIdle;
                    end else if (i_start && (w_eff_period != '0)) begin
                        r_y <= w_eff_period;
                    end else if (i_start || (i_ce && (r_y == W'(1)))) begin
                        // Terminal tick: explicit zero-period restart or count expiry.
                        r_tc <= 1'b1;
                        if (w_reload_ok) begin
                            r_y <= w_reload_val;
                        end else begin
                            r_y     <= '0;
                            r_state <= StIdle;
                        end
                    end else if (i_ce && (r_y > W'(1))) begin
                        r_y <= r_y - W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_y    = r_y;
    assign o_tc   = r_tc;
    assign o_busy = (r_state == StRun);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed vector table, an asynchronous
// reset sequence, then randomized stimulus against a behavioural model.
module tb_down_timer;

    localparam int unsigned N = 8;
    localparam int unsigned W = $clog2(N) + 1;

    logic         clk;
    logic         rst;
    logic         ce;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic [W-1:0] y;
    logic         tc;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    down_timer #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_ce          (ce),
        .i_load        (load),
        .i_load_val    (load_val),
        .i_start       (start),
        .i_stop        (stop),
        .i_auto_reload (auto_reload),
        .o_y           (y),
        .o_tc          (tc),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ce;
        logic         load;
        logic [W-1:0] lv;
        logic         start;
        logic         stop;
        logic         ar;
        logic [W-1:0] exp_y;
        logic         exp_tc;
        logic         exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int ey, input int etc, input int eb);
        check({tag, " y"}, int'(y), ey);
        check({tag, " tc"}, int'(tc), etc);
        check({tag, " busy"}, int'(busy), eb);
    endtask

    task automatic drive(input logic c, input logic l, input int lv, input logic s,
                         input logic sp, input logic ar);
        ce          = c;
        load        = l;
        load_val    = W'(lv);
        start       = s;
        stop        = sp;
        auto_reload = ar;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic c, input logic l, input int lv, input logic s,
                       input logic sp, input logic ar, input int ey, input logic etc,
                       input logic eb);
        vec_t v;
        v.ce = c; v.load = l; v.lv = W'(lv); v.start = s; v.stop = sp; v.ar = ar;
        v.exp_y = W'(ey); v.exp_tc = etc; v.exp_busy = eb;
        vecs.push_back(v);
    endtask

    // Behavioural reference: plain integers for running flag, count and period.
    int m_run, m_cnt, m_per, m_tc;

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_per = N; m_tc = 0;
    endtask

    task automatic model_step(input int c, input int l, input int lv, input int s,
                              input int sp, input int ar);
        int eff;
        int lvc;
        int term;
        lvc  = (lv > int'(N)) ? int'(N) : lv;
        eff  = l ? lvc : m_per;
        term = 0;
        m_tc = 0;
        if (m_run == 0) begin
            if (s != 0) begin
                if (eff > 0) begin
                    m_cnt = eff;
                    m_run = 1;
                end else begin
                    m_tc  = 1;
                    m_cnt = 0;
                end
            end
        end else if (sp != 0) begin
            m_run = 0;
        end else if (s != 0) begin
            if (eff > 0) m_cnt = eff;
            else term = 1;
        end else if (c != 0) begin
            if (m_cnt == 1) term = 1;
            else if (m_cnt > 1) m_cnt = m_cnt - 1;
        end
        if (term != 0) begin
            m_tc = 1;
            if (ar != 0 && m_per > 0) begin
                m_cnt = m_per;
            end else begin
                m_cnt = 0;
                m_run = 0;
            end
        end
        if (l != 0) m_per = lvc;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_outs("reset", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Full count from N, no reload.
        add(1, 0, 0, 1, 0, 0, 8, 0, 1);
        for (int k = 7; k >= 1; k--) add(1, 0, 0, 0, 0, 0, k, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Auto-reload period 3 for 12 ticks: four tc pulses.
        add(1, 1, 3, 1, 0, 1, 3, 0, 1);
        for (int k = 0; k < 12; k++) begin
            add(1, 0, 0, 0, 0, 1, (k % 3 == 2) ? 3 : 2 - (k % 3), (k % 3 == 2), 1);
        end
        add(0, 0, 0, 0, 1, 1, 3, 0, 0);
        // Over-range load clamped and used immediately.
        add(0, 1, 13, 1, 0, 0, 8, 0, 1);
        add(1, 0, 0, 0, 0, 0, 7, 0, 1);
        add(1, 0, 0, 0, 0, 0, 6, 0, 1);
        add(1, 0, 0, 0, 0, 0, 5, 0, 1);
        add(1, 0, 0, 0, 0, 0, 4, 0, 1);
        add(0, 0, 0, 0, 0, 0, 4, 0, 1);
        add(1, 0, 0, 0, 0, 0, 3, 0, 1);
        // stop beats start.
        add(1, 0, 0, 1, 1, 0, 3, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3, 0, 0);
        // Zero period: start gives a lone tc pulse, never busy.
        add(0, 1, 0, 0, 0, 0, 3, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Period 1 with auto-reload: tc every cycle.
        add(0, 1, 1, 1, 0, 1, 1, 0, 1);
        add(1, 0, 0, 0, 0, 1, 1, 1, 1);
        add(1, 0, 0, 0, 0, 1, 1, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ce, vecs[i].load, int'(vecs[i].lv), vecs[i].start,
                  vecs[i].stop, vecs[i].ar);
            tick();
            check_outs($sformatf("vec%0d", i), int'(vecs[i].exp_y), int'(vecs[i].exp_tc),
                       int'(vecs[i].exp_busy));
        end

        // Asynchronous reset mid-RUN, between clock edges.
        drive(0, 1, 6, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_outs("pre-rst", 4, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async-rst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        drive(0, 0, 0, 1, 0, 0);
        tick();
        check_outs("post-rst start", 8, 0, 1);

        // Randomized run against the model.
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        for (int i = 0; i < 600; i++) begin
            int c, l, lv, s, sp, ar;
            c  = ($urandom_range(0, 99) < 70) ? 1 : 0;
            l  = ($urandom_range(0, 99) < 8) ? 1 : 0;
            lv = $urandom_range(0, 15);
            s  = ($urandom_range(0, 99) < 10) ? 1 : 0;
            sp = ($urandom_range(0, 99) < 4) ? 1 : 0;
            ar = ($urandom_range(0, 99) < 60) ? 1 : 0;
            drive(c[0], l[0], lv, s[0], sp[0], ar[0]);
            model_step(c, l, lv, s, sp, ar);
            tick();
            check_outs($sformatf("rnd%0d", i), m_cnt, m_tc, m_run);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
